// File: rtl/serdes_drp_responder.sv
// rtl/serdes_drp_responder.sv - DRP target with programmable ready latency and a 16-bit register bank
// Flags initiator protocol violations (DRPEN while a transaction is still in flight).
module serdes_drp_responder #(
   parameter int          C_DEPTH       = 64,
   parameter int          C_RDY_LATENCY = 4,
   parameter logic [15:0] C_OOR_DATA    = 16'hDEAD,
   parameter logic [9:0]  C_RO_ADDR     = 10'h000
) (
   input  logic        I_drp_clk,
   input  logic        I_drp_rst,
   input  logic        I_drpen,
   input  logic        I_drpwe,
   input  logic [9:0]  I_drpaddr,
   input  logic [15:0] I_drpdi,
   output logic        O_drprdy,
   output logic [15:0] O_drpdo,
   input  logic [15:0] I_ro_status,
   output logic        O_wr_strobe,
   output logic [9:0]  O_wr_addr,
   output logic [15:0] O_wr_data,
   output logic        O_err_sticky,
   output logic [7:0]  O_err_cnt
);

   localparam int AW = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
   localparam logic [3:0] C_CNT_LOAD = 4'(C_RDY_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_next;
   logic        r_we;
   logic [9:0]  r_addr;
   logic [15:0] r_di;
   logic [15:0] r_bank [C_DEPTH];

   logic        w_accept;
   logic        w_complete;
   logic        w_busy_en;
   logic        w_c_we;
   logic [9:0]  w_c_addr;
   logic [15:0] w_c_di;
   logic [AW-1:0] w_c_idx;
   logic        w_c_in_range;
   logic        w_c_ro;
   logic        w_commit;
   logic [15:0] w_rd_data;

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_accept   = 1'b0;
      w_complete = 1'b0;
      w_busy_en  = 1'b0;
      case (r_state)
         S_IDLE, S_RESP: begin
            if (I_drpen) begin
               w_accept   = 1'b1;
               w_cnt_next = C_CNT_LOAD;
               if (C_RDY_LATENCY == 1) begin
                  w_next     = S_RESP;
                  w_complete = 1'b1;
               end else begin
                  w_next = S_BUSY;
               end
            end else begin
               w_next = S_IDLE;
            end
         end
         S_BUSY: begin
            w_busy_en = I_drpen;
            if (r_cnt == 4'd1) begin
               w_next     = S_RESP;
               w_complete = 1'b1;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // With a latency of 1 the transaction completes on the same edge that accepts it,
   // so the completing fields come straight from the inputs instead of the capture regs.
   always_comb begin
      if (r_state == S_BUSY) begin
         w_c_we   = r_we;
         w_c_addr = r_addr;
         w_c_di   = r_di;
      end else begin
         w_c_we   = I_drpwe;
         w_c_addr = I_drpaddr;
         w_c_di   = I_drpdi;
      end
   end

   assign w_c_idx      = w_c_addr[AW-1:0];
   assign w_c_in_range = (32'(w_c_addr) < C_DEPTH);
   assign w_c_ro       = (w_c_addr == C_RO_ADDR);
   assign w_commit     = w_complete && w_c_we && w_c_in_range && !w_c_ro;
   assign w_rd_data    = w_c_ro ? I_ro_status :
                         (!w_c_in_range ? C_OOR_DATA : r_bank[w_c_idx]);

   always_ff @(posedge I_drp_clk or posedge I_drp_rst) begin
      if (I_drp_rst) begin
         r_state      <= S_IDLE;
         r_cnt        <= 4'd0;
         r_we         <= 1'b0;
         r_addr       <= 10'd0;
         r_di         <= 16'd0;
         O_drprdy     <= 1'b0;
         O_drpdo      <= 16'd0;
         O_wr_strobe  <= 1'b0;
         O_wr_addr    <= 10'd0;
         O_wr_data    <= 16'd0;
         O_err_sticky <= 1'b0;
         O_err_cnt    <= 8'd0;
         for (int i = 0; i < C_DEPTH; i++) begin
            r_bank[i] <= 16'd0;
         end
      end else begin
         r_state     <= w_next;
         r_cnt       <= w_cnt_next;
         O_drprdy    <= w_complete;
         O_wr_strobe <= w_commit;
         if (w_accept) begin
            r_we   <= I_drpwe;
            r_addr <= I_drpaddr;
            r_di   <= I_drpdi;
         end
         if (w_commit) begin
            r_bank[w_c_idx] <= w_c_di;
            O_wr_addr       <= w_c_addr;
            O_wr_data       <= w_c_di;
         end
         if (w_complete && !w_c_we) begin
            O_drpdo <= w_rd_data;
         end
         if (w_busy_en) begin
            O_err_sticky <= 1'b1;
            if (O_err_cnt != 8'hFF) begin
               O_err_cnt <= O_err_cnt + 8'd1;
            end
         end
      end
   end

endmodule
